imm_extend_slice: RTL and testbench



---
 rtl/imm_extend_slice_if.sv | 24 ++
 rtl/imm_extend_slice.sv | 118 +++++++++++
 tb/tb_imm_extend_slice.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imm_extend_slice_if.sv
// Valid/ready bus between the immediate extender slice and its producer/consumer.
// The slice uses the slave modport; the environment drives through master.
interface imm_extend_slice_if #(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned OUT_W = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;

    modport slave (
        input  in_valid, in_data, in_mode, out_ready,
        output in_ready, out_valid, out_data
    );

    modport master (
        output in_valid, in_data, in_mode, out_ready,
        input  in_ready, out_valid, out_data
    );
endinterface

// File: rtl/imm_extend_slice.sv
// Immediate extender (zero/sign/upper/replicate) behind a valid/ready slice with skid buffer.
// Optional macro EXT_REPL_EN enables mode 11 bit-replicate; otherwise mode 11 zero-extends.
module imm_extend_slice #(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned OUT_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    imm_extend_slice_if.slave   bus
);

    localparam int unsigned PAD = OUT_W - IN_W;
    localparam logic [OUT_W-1:0] HI_MASK = {OUT_W{1'b1}} << IN_W;

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ONE   = 2'd1;
    localparam logic [1:0] S_FULL  = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic             r_out_valid;
    logic             r_in_ready;
    logic [OUT_W-1:0] r_out_data;
    logic [OUT_W-1:0] r_skid_data;
    logic [OUT_W-1:0] w_ext;
    logic             w_accept;
    logic             w_emit;
    logic             w_load_out;
    logic             w_load_skid;
    logic             w_skid_to_out;

    assign w_accept = bus.in_valid & r_in_ready;
    assign w_emit   = r_out_valid & bus.out_ready;

    // Extension happens before storage so both registers hold finished words.
    always_comb begin
        w_ext = OUT_W'(bus.in_data);
        case (bus.in_mode)
            2'b00: w_ext = OUT_W'(bus.in_data);
            2'b01: w_ext = OUT_W'(bus.in_data) | (bus.in_data[IN_W-1] ? HI_MASK : '0);
            2'b10: w_ext = OUT_W'(bus.in_data) << PAD;
            2'b11: begin
`ifdef EXT_REPL_EN
                w_ext = {OUT_W{bus.in_data[0]}};
`else
                w_ext = OUT_W'(bus.in_data);
`endif
            end
            default: w_ext = OUT_W'(bus.in_data);
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and datapath steering; FULL never accepts since in_ready is low there.
    always_comb begin
        w_state_nxt   = r_state;
        w_load_out    = 1'b0;
        w_load_skid   = 1'b0;
        w_skid_to_out = 1'b0;
        case (r_state)
            S_EMPTY: begin
                if (w_accept) begin
                    w_state_nxt = S_ONE;
                    w_load_out  = 1'b1;
                end
            end
            S_ONE: begin
                if (w_accept && w_emit) begin
                    w_load_out = 1'b1;
                end else if (w_accept) begin
                    w_state_nxt = S_FULL;
                    w_load_skid = 1'b1;
                end else if (w_emit) begin
                    w_state_nxt = S_EMPTY;
                end
            end
            S_FULL: begin
                if (w_emit) begin
                    w_state_nxt   = S_ONE;
                    w_skid_to_out = 1'b1;
                end
            end
            default: w_state_nxt = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_data  <= '0;
            r_skid_data <= '0;
        end else begin
            r_out_valid <= (w_state_nxt != S_EMPTY);
            r_in_ready  <= (w_state_nxt != S_FULL);
            if (w_load_out) begin
                r_out_data <= w_ext;
            end else if (w_skid_to_out) begin
                r_out_data <= r_skid_data;
            end
            if (w_load_skid) begin
                r_skid_data <= w_ext;
            end
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;

endmodule

// File: tb/tb_imm_extend_slice.sv
// Directed and scoreboarded checks for imm_extend_slice (16->32 main, 32->32 boundary instance).
module tb_imm_extend_slice;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    imm_extend_slice_if #(.IN_W(16), .OUT_W(32)) bus ();
    imm_extend_slice #(.IN_W(16), .OUT_W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    imm_extend_slice_if #(.IN_W(32), .OUT_W(32)) bus32 ();
    imm_extend_slice #(.IN_W(32), .OUT_W(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));

    function automatic logic [31:0] ref_ext(input logic [15:0] d, input logic [1:0] m);
        case (m)
            2'b00: return {16'h0000, d};
            2'b01: return {{16{d[15]}}, d};
            2'b10: return {d, 16'h0000};
            default: begin
`ifdef EXT_REPL_EN
                return {32{d[0]}};
`else
                return {16'h0000, d};
`endif
            end
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.in_valid  = 1'($urandom);
            bus.in_data   = 16'($urandom);
            bus.in_mode   = 2'($urandom);
            bus.out_ready = 1'($urandom);
            tick();
            total++;
            if (bus.out_valid !== 1'b0 || bus.out_data !== 32'h0 || bus.in_ready !== 1'b1) begin
                bad++;
                $display("FAIL reset cyc=%0d got v=%b d=%h r=%b exp v=0 d=00000000 r=1",
                         i, bus.out_valid, bus.out_data, bus.in_ready);
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        rst_n = 1'b1;
    endtask

    task automatic test_modes();
        logic [15:0] din [0:1];
        logic [31:0] exp_tab [0:7];
        din[0] = 16'h8001;
        din[1] = 16'h7FFE;
        exp_tab[0] = 32'h0000_8001;
        exp_tab[1] = 32'hFFFF_8001;
        exp_tab[2] = 32'h8001_0000;
`ifdef EXT_REPL_EN
        exp_tab[3] = 32'hFFFF_FFFF;
`else
        exp_tab[3] = 32'h0000_8001;
`endif
        exp_tab[4] = 32'h0000_7FFE;
        exp_tab[5] = 32'h0000_7FFE;
        exp_tab[6] = 32'h7FFE_0000;
`ifdef EXT_REPL_EN
        exp_tab[7] = 32'h0000_0000;
`else
        exp_tab[7] = 32'h0000_7FFE;
`endif
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.in_data = din[i / 4];
            bus.in_mode = i[1:0];
            tick();
            total++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== exp_tab[i]) begin
                bad++;
                $display("FAIL modes idx=%0d got v=%b d=%h exp v=1 d=%h",
                         i, bus.out_valid, bus.out_data, exp_tab[i]);
            end
        end
        bus.in_valid = 1'b0;
        tick();
        total++;
        if (bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL modes_drain got v=%b exp v=0", bus.out_valid);
        end
    endtask

    task automatic test_latency();
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 16'hF00D;
        bus.in_mode   = 2'b01;
        tick();
        bus.in_valid = 1'b0;
        total++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 32'hFFFF_F00D) begin
            bad++;
            $display("FAIL latency_n got v=%b d=%h exp v=1 d=fffff00d", bus.out_valid, bus.out_data);
        end
        tick();
        total++;
        if (bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL latency_n1 got v=%b exp v=0", bus.out_valid);
        end
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_mode   = 2'b01;
        bus.in_data   = 16'h0001;
        tick();
        total++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h1 || bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_first got v=%b d=%h r=%b exp v=1 d=00000001 r=1",
                     bus.out_valid, bus.out_data, bus.in_ready);
        end
        bus.in_data = 16'h0002;
        tick();
        bus.in_valid = 1'b0;
        total++;
        if (bus.in_ready !== 1'b0 || bus.out_data !== 32'h1) begin
            bad++;
            $display("FAIL bp_full got r=%b d=%h exp r=0 d=00000001", bus.in_ready, bus.out_data);
        end
        tick();
        total++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h1 || bus.in_ready !== 1'b0) begin
            bad++;
            $display("FAIL bp_hold got v=%b d=%h r=%b exp v=1 d=00000001 r=0",
                     bus.out_valid, bus.out_data, bus.in_ready);
        end
        bus.out_ready = 1'b1;
        tick();
        total++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h2 || bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_second got v=%b d=%h r=%b exp v=1 d=00000002 r=1",
                     bus.out_valid, bus.out_data, bus.in_ready);
        end
        tick();
        total++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_drain got v=%b r=%b exp v=0 r=1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_reset_full();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_mode   = 2'b00;
        bus.in_data   = 16'h00AA;
        tick();
        bus.in_data = 16'h00BB;
        tick();
        bus.in_valid = 1'b0;
        total++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
            bad++;
            $display("FAIL rst_fill got r=%b v=%b exp r=0 v=1", bus.in_ready, bus.out_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 32'h0 || bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL rst_async got v=%b d=%h r=%b exp v=0 d=00000000 r=1",
                     bus.out_valid, bus.out_data, bus.in_ready);
        end
        tick();
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 16'h0003;
        tick();
        bus.in_valid = 1'b0;
        total++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h3) begin
            bad++;
            $display("FAIL rst_first_accept got v=%b d=%h exp v=1 d=00000003", bus.out_valid, bus.out_data);
        end
        tick();
        total++;
        if (bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL rst_drain got v=%b exp v=0 (stale skid entry)", bus.out_valid);
        end
    endtask

    task automatic test_streaming();
        logic [31:0] q [$];
        logic [31:0] hold_data;
        logic        hold;
        logic        prev_ready;
        int          sent = 0;
        int          got = 0;
        int          cyc = 0;
        while ((sent < 100 || got < 100) && cyc < 3000) begin
            bus.in_valid  = (sent < 100) ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.in_data   = 16'($urandom);
            bus.in_mode   = 2'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (bus.in_valid && bus.in_ready) begin
                q.push_back(ref_ext(bus.in_data, bus.in_mode));
                sent++;
            end
            if (bus.out_valid && bus.out_ready) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL stream_extra got d=%h with empty scoreboard", bus.out_data);
                end else begin
                    if (bus.out_data !== q[0]) begin
                        bad++;
                        $display("FAIL stream_data n=%0d got=%h exp=%h", got, bus.out_data, q[0]);
                    end
                    void'(q.pop_front());
                end
                got++;
            end
            hold       = bus.out_valid && !bus.out_ready;
            hold_data  = bus.out_data;
            prev_ready = bus.out_ready;
            tick();
            cyc++;
            if (hold) begin
                total++;
                if (bus.out_valid !== 1'b1 || bus.out_data !== hold_data) begin
                    bad++;
                    $display("FAIL stream_stable got v=%b d=%h exp v=1 d=%h",
                             bus.out_valid, bus.out_data, hold_data);
                end
            end
            if (prev_ready) begin
                total++;
                if (bus.in_ready !== 1'b1) begin
                    bad++;
                    $display("FAIL stream_ready got r=%b exp r=1 after out_ready cycle", bus.in_ready);
                end
            end
        end
        bus.in_valid = 1'b0;
        total++;
        if (cyc >= 3000 || got != 100 || q.size() != 0) begin
            bad++;
            $display("FAIL stream_count got sent=%0d recv=%0d left=%0d exp 100/100/0",
                     sent, got, q.size());
        end
    endtask

    task automatic test_boundary();
        bus32.out_ready = 1'b1;
        bus32.in_valid  = 1'b1;
        bus32.in_data   = 32'h8000_0000;
        bus32.in_mode   = 2'b01;
        tick();
        total++;
        if (bus32.out_valid !== 1'b1 || bus32.out_data !== 32'h8000_0000) begin
            bad++;
            $display("FAIL bound_sign got v=%b d=%h exp v=1 d=80000000", bus32.out_valid, bus32.out_data);
        end
        bus32.in_mode = 2'b10;
        tick();
        total++;
        if (bus32.out_data !== 32'h8000_0000) begin
            bad++;
            $display("FAIL bound_upper got d=%h exp d=80000000", bus32.out_data);
        end
        bus32.in_data = 32'h1234_5679;
        bus32.in_mode = 2'b00;
        tick();
        total++;
        if (bus32.out_data !== 32'h1234_5679) begin
            bad++;
            $display("FAIL bound_zero got d=%h exp d=12345679", bus32.out_data);
        end
        bus32.in_mode = 2'b11;
        tick();
        bus32.in_valid = 1'b0;
        total++;
`ifdef EXT_REPL_EN
        if (bus32.out_data !== 32'hFFFF_FFFF) begin
            bad++;
            $display("FAIL bound_repl got d=%h exp d=ffffffff", bus32.out_data);
        end
`else
        if (bus32.out_data !== 32'h1234_5679) begin
            bad++;
            $display("FAIL bound_repl got d=%h exp d=12345679", bus32.out_data);
        end
`endif
        tick();
    endtask

    initial begin
        bus.in_valid    = 1'b0;
        bus.in_data     = '0;
        bus.in_mode     = '0;
        bus.out_ready   = 1'b1;
        bus32.in_valid  = 1'b0;
        bus32.in_data   = '0;
        bus32.in_mode   = '0;
        bus32.out_ready = 1'b1;
        test_reset();
        test_modes();
        test_latency();
        test_backpressure();
        test_reset_full();
        test_streaming();
        test_boundary();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
